// File: rtl/iob_dbus_split.sv
// Data-bus splitter: routes native-interface requests to one of N_SLAVES slaves by an address field.
// Latency: zero added on forward/return paths; decode error answers 1 cycle later, timeout after 2^TIMEOUT_W cycles.
// Backpressure: one outstanding transaction; the master is held until the slave, a decode error or a timeout answers.
module iob_dbus_split #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_SLAVES  = 2,
  parameter int P_SLAVES  = ADDR_W - 1,
  parameter int TIMEOUT_W = 8,
  parameter logic [DATA_W-1:0] ERR_RDATA = '0,
  localparam int STRB_W = DATA_W / 8,
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int RESP_W = DATA_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_W-1:0]           m_req,
  output logic [RESP_W-1:0]          m_resp,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [ADDR_W-1:0]          err_addr
);
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [SEL_W:0] N_SEL = (SEL_W+1)'(N_SLAVES);
  localparam logic [TIMEOUT_W-1:0] LIMIT = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DERR} state_t;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     sel_reg, sel_nxt, dec_sel, fwd_sel;
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic                 m_valid, dec_ok;
  logic [ADDR_W-1:0]    m_addr;
  logic [RESP_W-1:0]    sel_resp;
  logic                 fwd_en, pass_en, err_resp, tmo_hit, derr_hit;

  assign m_valid = m_req[REQ_W-1];
  assign m_addr  = m_req[REQ_W-2 -: ADDR_W];
  assign dec_sel = m_addr[P_SLAVES -: SEL_W];
  assign dec_ok  = ({1'b0, dec_sel} < N_SEL);
  // A new request is decoded only in IDLE; otherwise the latched slave owns the bus.
  assign fwd_sel = (state == IDLE) ? dec_sel : sel_reg;

  // Pick the response of the slave currently addressed (zero for an out-of-range select).
  always_comb begin
    sel_resp = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (fwd_sel == SEL_W'(k)) sel_resp = s_resp[k*RESP_W +: RESP_W];
    end
  end

  // Next-state logic: accept, wait for ready, answer decode errors and timeouts locally.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_reg;
    cnt_nxt   = cnt;
    fwd_en    = 1'b0;
    pass_en   = 1'b0;
    err_resp  = 1'b0;
    tmo_hit   = 1'b0;
    derr_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (m_valid) begin
          if (dec_ok) begin
            fwd_en  = 1'b1;
            pass_en = 1'b1;
            if (!sel_resp[0]) begin
              state_nxt = BUSY;
              sel_nxt   = dec_sel;
              cnt_nxt   = '0;
            end
          end else begin
            state_nxt = DERR;
          end
        end
      end
      BUSY: begin
        fwd_en  = 1'b1;
        pass_en = 1'b1;
        if (sel_resp[0]) begin
          state_nxt = IDLE;
        end else if (cnt == LIMIT) begin
          err_resp  = 1'b1;
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DERR: begin
        err_resp  = 1'b1;
        derr_hit  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output steering; everything is forced quiet while reset is asserted.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    if (!rst) begin
      for (int k = 0; k < N_SLAVES; k++) begin
        if (fwd_en && fwd_sel == SEL_W'(k)) s_req[k*REQ_W +: REQ_W] = m_req;
      end
      if (pass_en && sel_resp[0]) m_resp = sel_resp;
      else if (err_resp)          m_resp = {ERR_RDATA, 1'b1};
    end
  end

  // State, latched slave select and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_reg <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      sel_reg <= sel_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Sticky error status; the address is kept from the first error only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_code <= 2'b00;
      err_addr <= '0;
    end else if (tmo_hit || derr_hit) begin
      if (!err) err_addr <= m_addr;
      err      <= 1'b1;
      err_code <= err_code | {derr_hit, tmo_hit};
    end
  end

endmodule

// File: tb/tb_iob_dbus_split.sv
module tb_iob_dbus_split;
  logic clk;
  logic rst;

  // Instance A: 2 slaves, short timeout. Instance B: 3 slaves, nonzero error rdata.
  logic [68:0]  a_mreq;
  logic [32:0]  a_mresp;
  logic [137:0] a_sreq;
  logic [65:0]  a_sresp;
  logic         a_err;
  logic [1:0]   a_code;
  logic [31:0]  a_eaddr;

  logic [68:0]  b_mreq;
  logic [32:0]  b_mresp;
  logic [206:0] b_sreq;
  logic [98:0]  b_sresp;
  logic         b_err;
  logic [1:0]   b_code;
  logic [31:0]  b_eaddr;

  int checks;
  int failures;

  iob_dbus_split #(.N_SLAVES(2), .TIMEOUT_W(4)) u_a (
    .clk(clk), .rst(rst), .m_req(a_mreq), .m_resp(a_mresp), .s_req(a_sreq),
    .s_resp(a_sresp), .err(a_err), .err_code(a_code), .err_addr(a_eaddr)
  );

  iob_dbus_split #(.N_SLAVES(3), .TIMEOUT_W(4), .ERR_RDATA(32'hDEAD_0000)) u_b (
    .clk(clk), .rst(rst), .m_req(b_mreq), .m_resp(b_mresp), .s_req(b_sreq),
    .s_resp(b_sresp), .err(b_err), .err_code(b_code), .err_addr(b_eaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [68:0] mk_req(input logic v, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [32:0] mk_resp(input logic [31:0] d, input logic r);
    return {d, r};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    string        nm;
    logic [68:0]  req;
    logic [65:0]  sresp;
    logic [137:0] exp_sreq;
    logic [32:0]  exp_mresp;
  } vec_t;

  vec_t vecs[5];
  logic [68:0] ra, rb;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a_mreq = mk_req(1'b1, 32'h0000_0004, 32'h0, 4'h0);
    a_sresp = '0;
    b_mreq = '0;
    b_sresp = '0;

    // Vectors applied in IDLE; each either has no valid or a zero-wait selected slave.
    vecs[0] = '{"idle_ready_ignored", mk_req(1'b0, 32'h8000_0010, 32'h0, 4'h0),
                {mk_resp(32'h2222, 1'b1), mk_resp(32'h1111, 1'b1)}, '0, '0};
    ra = mk_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011);
    vecs[1] = '{"write_s0_zero_wait", ra,
                {mk_resp(32'h2222, 1'b1), mk_resp(32'h1111, 1'b1)}, {69'b0, ra}, mk_resp(32'h1111, 1'b1)};
    ra = mk_req(1'b1, 32'h8000_0010, 32'h0, 4'h0);
    vecs[2] = '{"read_s1_zero_wait", ra,
                {mk_resp(32'hCAFE_0001, 1'b1), mk_resp(32'h5555, 1'b1)}, {ra, 69'b0}, mk_resp(32'hCAFE_0001, 1'b1)};
    ra = mk_req(1'b1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 4'b1111);
    vecs[3] = '{"write_s1_s0_notready", ra,
                {mk_resp(32'h0000_0007, 1'b1), mk_resp(32'h9999, 1'b0)}, {ra, 69'b0}, mk_resp(32'h7, 1'b1)};
    vecs[4] = '{"idle_quiet", '0, '0, '0, '0};

    // Reset state with a valid request present.
    #2;
    chk("rst_a_sreq", a_sreq, '0);
    chk("rst_a_mresp", a_mresp, '0);
    chk("rst_a_err", {a_err, a_code, a_eaddr}, '0);
    chk("rst_b_err", {b_err, b_code, b_eaddr}, '0);
    a_mreq = '0;
    adv();
    rst = 1'b0;

    // Table-driven single-cycle transactions on instance A.
    for (int i = 0; i < 5; i++) begin
      adv();
      a_mreq  = vecs[i].req;
      a_sresp = vecs[i].sresp;
      smp();
      chk({vecs[i].nm, "_sreq"}, a_sreq, vecs[i].exp_sreq);
      chk({vecs[i].nm, "_mresp"}, a_mresp, vecs[i].exp_mresp);
    end
    chk("table_err_clear", {a_err, a_code}, '0);

    // Read slave 1 with ready after 3 cycles; non-ready rdata must not leak.
    adv();
    ra = mk_req(1'b1, 32'h8000_0010, 32'h0, 4'h0);
    a_mreq = ra;
    a_sresp = '0;
    smp();
    chk("rd3_c0_sreq", a_sreq, {ra, 69'b0});
    chk("rd3_c0_mresp", a_mresp, '0);
    for (int c = 1; c <= 2; c++) begin
      adv();
      a_sresp = {mk_resp(32'hBAD0_0BAD, 1'b0), mk_resp(32'h1, 1'b1)};
      smp();
      chk("rd3_wait_mresp", a_mresp, '0);
      chk("rd3_wait_sreq", a_sreq, {ra, 69'b0});
    end
    adv();
    a_sresp = {mk_resp(32'h1234_5678, 1'b1), mk_resp(32'h0, 1'b0)};
    smp();
    chk("rd3_c3_mresp", a_mresp, mk_resp(32'h1234_5678, 1'b1));
    adv();
    a_mreq = '0;
    a_sresp = '0;
    smp();
    chk("rd3_after_mresp", a_mresp, '0);
    chk("rd3_err", a_err, 1'b0);

    // Back-to-back reads to alternating slaves, valid held through ready.
    adv();
    ra = mk_req(1'b1, 32'h0000_0100, 32'h0, 4'h0);
    rb = mk_req(1'b1, 32'h8000_0200, 32'h0, 4'h0);
    a_mreq = ra;
    smp();
    chk("b2b_a_accept", a_mresp, '0);
    adv();
    a_sresp = {mk_resp(32'hBBBB, 1'b1), mk_resp(32'hAAAA, 1'b1)};
    smp();
    chk("b2b_a_mresp", a_mresp, mk_resp(32'hAAAA, 1'b1));
    chk("b2b_a_sreq", a_sreq, {69'b0, ra});
    adv();
    a_mreq = rb;
    a_sresp = {mk_resp(32'hBBBB, 1'b1), mk_resp(32'hAAAA, 1'b0)};
    smp();
    chk("b2b_b_sreq", a_sreq, {rb, 69'b0});
    chk("b2b_b_mresp", a_mresp, mk_resp(32'hBBBB, 1'b1));
    adv();
    a_mreq = '0;
    a_sresp = '0;

    // Instance B: slave 2 routing, decode errors, then a timeout.
    adv();
    rb = mk_req(1'b1, 32'h8000_0000, 32'h0000_1234, 4'b1111);
    b_mreq = rb;
    b_sresp = {mk_resp(32'h3333, 1'b1), mk_resp(32'h0, 1'b0), mk_resp(32'h0, 1'b0)};
    smp();
    chk("b_s2_sreq", b_sreq, {rb, 138'b0});
    chk("b_s2_mresp", b_mresp, mk_resp(32'h3333, 1'b1));
    for (int n = 0; n < 2; n++) begin
      adv();
      b_mreq = mk_req(1'b1, (n == 0) ? 32'hC000_0004 : 32'hC000_0008, 32'h0, 4'h0);
      b_sresp = {mk_resp(32'h3, 1'b1), mk_resp(32'h2, 1'b1), mk_resp(32'h1, 1'b1)};
      smp();
      chk("derr_c0_sreq", b_sreq, '0);
      chk("derr_c0_mresp", b_mresp, '0);
      adv();
      smp();
      chk("derr_c1_mresp", b_mresp, mk_resp(32'hDEAD_0000, 1'b1));
      chk("derr_c1_sreq", b_sreq, '0);
      adv();
      b_mreq = '0;
      b_sresp = '0;
      smp();
      chk("derr_after_mresp", b_mresp, '0);
      chk("derr_status", {b_err, b_code, b_eaddr}, {1'b1, 2'b10, 32'hC000_0004});
    end
    adv();
    b_mreq = mk_req(1'b1, 32'h0000_0050, 32'h0, 4'h0);
    for (int c = 1; c <= 16; c++) begin
      adv();
      smp();
      if (c == 16) chk("b_tmo_mresp", b_mresp, mk_resp(32'hDEAD_0000, 1'b1));
      else         chk("b_tmo_wait", b_mresp, '0);
    end
    adv();
    b_mreq = '0;
    smp();
    chk("b_tmo_status", {b_err, b_code, b_eaddr}, {1'b1, 2'b11, 32'hC000_0004});

    // Instance A timeout, then a late ready that must be dropped.
    adv();
    ra = mk_req(1'b1, 32'h0000_0ABC, 32'h0, 4'h0);
    a_mreq = ra;
    for (int c = 1; c <= 16; c++) begin
      adv();
      smp();
      if (c == 16) chk("a_tmo_mresp", a_mresp, mk_resp(32'h0, 1'b1));
      else         chk("a_tmo_wait", a_mresp, '0);
    end
    adv();
    a_mreq = '0;
    smp();
    chk("a_tmo_status", {a_err, a_code, a_eaddr}, {1'b1, 2'b01, 32'h0000_0ABC});
    adv();
    adv();
    adv();
    a_sresp = {mk_resp(32'h0, 1'b0), mk_resp(32'h77, 1'b1)};
    smp();
    chk("late_ready_mresp", a_mresp, '0);
    chk("late_ready_sreq", a_sreq, '0);
    adv();
    a_sresp = '0;

    // Reset asserted in BUSY cycle 2, then a fresh read to slave 0.
    adv();
    a_mreq = mk_req(1'b1, 32'h0000_0020, 32'h0, 4'h0);
    adv();
    adv();
    rst = 1'b1;
    #1;
    chk("midrst_sreq", a_sreq, '0);
    chk("midrst_mresp", a_mresp, '0);
    chk("midrst_a_status", {a_err, a_code, a_eaddr}, '0);
    chk("midrst_b_status", {b_err, b_code, b_eaddr}, '0);
    adv();
    rst = 1'b0;
    ra = mk_req(1'b1, 32'h0000_0024, 32'h0, 4'h0);
    a_mreq = ra;
    smp();
    chk("postrst_sreq", a_sreq, {69'b0, ra});
    chk("postrst_wait", a_mresp, '0);
    adv();
    a_sresp = {mk_resp(32'h0, 1'b0), mk_resp(32'h600D, 1'b1)};
    smp();
    chk("postrst_mresp", a_mresp, mk_resp(32'h600D, 1'b1));
    adv();
    a_mreq = '0;
    a_sresp = '0;
    smp();
    chk("postrst_err", {a_err, a_code}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
